median5_stream: RTL and testbench
=================================

# median5_stream

Streaming sliding-window median filter, window of 5, placed directly downstream of the two-operand adder `Foo`: its `c` result stream enters here and the filtered stream leaves toward the result sink/testbench. Valid/ready handshake on both sides, 2-stage comparator pipeline, warm-up suppression until the window is full, synchronous `clear` to restart the window.

## Interface
- `WIDTH`, 16, sample width in bits (matches adder result width).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `clear`  in  1  synchronous window flush, active-high.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  WIDTH  sample (adder `c`).
- `out_valid`  out  1  median result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  WIDTH  median of last 5 accepted samples.

## Operation
- Window: 5-entry shift register w0 (newest) .. w4 (oldest); shifts on every accept (`in_valid && in_ready`).
- Fill FSM: states FILL, RUN. Counter `fill_cnt` 0..4 in FILL; accept increments it; the 5th accept moves to RUN. RUN stays until `clear` or reset.
- Window is "complete" on an accept that occurs in RUN or that takes FILL to RUN; only complete windows issue a job into the pipeline. Accepts in FILL with count <4 shift only.
- Stage 1 (`s1`): registers partial comparator-network results (min/max of pairs plus carried element) and `s1_valid`.
- Stage 2 (output): registers final median into `out_data`, sets `out_valid`.
- Median is the 3rd-smallest of the 5 entries; duplicates allowed; ties yield the duplicated value.
- Comparison unsigned unless the signed option is compiled in (see Configuration).
- Advance: `adv = !out_valid || out_ready`. `in_ready = adv`. When `adv` low, window, `s1` and output all hold.
- Output handshake: `out_data` and `out_valid` stable while `out_valid && !out_ready`.
- `clear` (when `reset` deasserted): FSM to FILL, `fill_cnt`=0, `s1_valid`=0, `out_valid`=0; window contents need not be zeroed; `in_ready` forced 0 in the `clear` cycle; an accept coincident with `clear` cannot occur.
- Reset values: `out_valid`=0, `out_data`=0, `in_ready`=1 after reset release (0 while `reset` asserted), FSM=FILL, `fill_cnt`=0, `s1_valid`=0, window=0.

## Timing
- Latency: completing accept at edge k -> `s1` loaded at edge k+1 -> `out_valid`=1 after edge k+2 (if `adv` held high).
- Throughput: 1 result/cycle once in RUN with `out_ready`=1.
- First output only after 5th accepted sample; samples 1..4 produce no output.
- Stall: `out_ready`=0 with `out_valid`=1 drops `in_ready` in the same cycle (combinational from `out_valid`/`out_ready`); no data loss, no duplication.
- Bubbles: a cycle with no accept while `adv`=1 inserts a bubble (`s1_valid`=0) which propagates; `out_valid` drops after the last valid result is consumed.
- Reset mid-operation: all state cleared immediately (async); pending results discarded.

## Configuration
- `MEDIAN5_SIGNED_EN`: defined -> all comparisons treat samples as two's-complement signed; not defined -> unsigned comparison. Datapath widths unchanged either way.

## Structure
- Package `median5_pkg`: `localparam WINDOW = 5`, `MED_IDX = 2`, enum `fill_state_e {FILL, RUN}`, fill counter width constant.
- Sub-module `median5_net`: purely combinational 5-input median network, split into `stage_a` and `stage_b` outputs so the top registers between them; instantiated once.
- Top holds window, FSM, handshake, and pipeline registers.

## Test plan
- Feed 5,1,4,2,3 with `out_ready`=1 -> no output for first 4; `out_data`=3 exactly 2 cycles after 5th accept.
- Continue with 9,9,0 after above -> outputs 3, 4, 3 on consecutive cycles (windows {1,4,2,3,9},{4,2,3,9,9},{2,3,9,9,0}).
- Hold `out_ready`=0 for 4 cycles mid-stream -> `in_ready`=0, `out_data` stable; on release, sequence resumes with no drop/duplicate.
- Assert `clear` after 7 samples, then feed 10,20,30,40,50 -> no output until 5th post-clear sample, result 30.
- Pulse `reset`=0 asynchronously mid-stream -> `out_valid`=0, `out_data`=0 immediately; next output only after 5 new samples.
- With `MEDIAN5_SIGNED_EN`, WIDTH=16, feed 0xFFFF,1,2,0x8000,3 -> median 1; without macro -> median 3.

Source files
------------

// File: rtl/median5_pkg.sv
// Shared constants and types for the 5-tap streaming median filter.
package median5_pkg;

  localparam int WINDOW     = 5;
  localparam int MED_IDX    = 2;
  // After discarding one element known to lie below the median and one known
  // to lie above it, MED_IDX+1 candidates remain for the final pick.
  localparam int STAGE_A_N  = MED_IDX + 1;
  localparam int FILL_CNT_W = 3;

  localparam logic [FILL_CNT_W-1:0] FILL_LAST = FILL_CNT_W'(WINDOW - 1);

  typedef enum logic {
    FILL,
    RUN
  } fill_state_e;

endpackage

// File: rtl/median5_stream_if.sv
// Input and output valid/ready streams of the median filter, bundled together.
interface median5_stream_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/median5_net.sv
// Combinational 5-input median network, split into two halves for pipelining.
// Define MEDIAN5_SIGNED_EN to compare samples as two's-complement signed.
module median5_net
  import median5_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] win        [WINDOW],
  output logic [WIDTH-1:0] stage_a    [STAGE_A_N],
  input  logic [WIDTH-1:0] stage_b_in [STAGE_A_N],
  output logic [WIDTH-1:0] stage_b
);

  function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MEDIAN5_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] vmin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return less(b, a) ? b : a;
  endfunction

  function automatic logic [WIDTH-1:0] vmax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return less(a, b) ? b : a;
  endfunction

  logic [WIDTH-1:0] lo_a;
  logic [WIDTH-1:0] hi_a;
  logic [WIDTH-1:0] lo_b;
  logic [WIDTH-1:0] hi_b;

  // Sort two pairs; the smaller low and the larger high can never be the median.
  always_comb begin
    lo_a       = vmin(win[0], win[1]);
    hi_a       = vmax(win[0], win[1]);
    lo_b       = vmin(win[2], win[3]);
    hi_b       = vmax(win[2], win[3]);
    stage_a[0] = vmax(lo_a, lo_b);
    stage_a[1] = vmin(hi_a, hi_b);
    stage_a[2] = win[4];
  end

  logic [WIDTH-1:0] pair_lo;
  logic [WIDTH-1:0] pair_hi;

  always_comb begin
    pair_lo = vmin(stage_b_in[0], stage_b_in[1]);
    pair_hi = vmax(stage_b_in[0], stage_b_in[1]);
    stage_b = vmax(pair_lo, vmin(pair_hi, stage_b_in[2]));
  end

endmodule

// File: rtl/median5_stream.sv
// Streaming sliding-window median of 5 with warm-up suppression and a 2-stage pipeline.
// Comparison signedness follows MEDIAN5_SIGNED_EN (see median5_net).
module median5_stream
  import median5_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  median5_stream_if.slave   bus
);

  logic adv;
  logic accept;
  logic complete;

  fill_state_e           state_reg;
  fill_state_e           state_next;
  logic [FILL_CNT_W-1:0] fill_cnt_reg;
  logic [FILL_CNT_W-1:0] fill_cnt_next;

  logic [WIDTH-1:0] window_reg  [WINDOW];
  logic [WIDTH-1:0] window_next [WINDOW];

  logic             job_reg;
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_reg [STAGE_A_N];
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;

  logic [WIDTH-1:0] stage_a [STAGE_A_N];
  logic [WIDTH-1:0] stage_b;

  assign adv          = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = reset && !clear && adv;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    complete      = 1'b0;
    if (clear) begin
      state_next    = FILL;
      fill_cnt_next = '0;
    end else if (accept) begin
      case (state_reg)
        FILL: begin
          if (fill_cnt_reg == FILL_LAST) begin
            state_next = RUN;
            complete   = 1'b1;
          end else begin
            fill_cnt_next = fill_cnt_reg + 1'b1;
          end
        end
        RUN:     complete = 1'b1;
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= FILL;
      fill_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
    end
  end

  // Newest sample enters at index 0; everything else moves one slot older.
  assign window_next[0] = bus.in_data;
  for (genvar gi = 1; gi < WINDOW; gi++) begin : g_shift
    assign window_next[gi] = window_reg[gi-1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WINDOW; i++) window_reg[i] <= '0;
    end else if (accept) begin
      window_reg <= window_next;
    end
  end

  median5_net #(
    .WIDTH (WIDTH)
  ) u_net (
    .win        (window_reg),
    .stage_a    (stage_a),
    .stage_b_in (s1_reg),
    .stage_b    (stage_b)
  );

  // job_reg marks that window_reg now holds a complete window awaiting stage 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      job_reg       <= 1'b0;
      s1_valid_reg  <= 1'b0;
      for (int i = 0; i < STAGE_A_N; i++) s1_reg[i] <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (clear) begin
      job_reg       <= 1'b0;
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (adv) begin
      job_reg      <= complete;
      s1_valid_reg <= job_reg;
      if (job_reg) begin
        s1_reg <= stage_a;
      end
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg <= stage_b;
      end
    end
  end

endmodule

// File: tb/tb_median5_stream.sv
// Directed self-checking bench for median5_stream.
module tb_median5_stream;

  logic clock;
  logic reset;
  logic clear;
  int   checks;
  int   errors;

  median5_stream_if #(.WIDTH(16)) bus ();

  median5_stream #(
    .WIDTH (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy, input logic clr);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clear         = clr;
    @(posedge clock);
    #1;
    $display("t=%0t in_valid=%0b in_data=%h out_ready=%0b clear=%0b -> out_valid=%0b out_data=%h in_ready=%0b",
             $time, iv, d, ordy, clr, bus.out_valid, bus.out_data, bus.in_ready);
  endtask

  logic [15:0] signed_exp;

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", {15'b0, bus.out_valid}, 16'd0);
    chk("rst_out_data", bus.out_data, 16'd0);
    chk("rst_in_ready", {15'b0, bus.in_ready}, 16'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rel_in_ready", {15'b0, bus.in_ready}, 16'd1);
    chk("rel_out_valid", {15'b0, bus.out_valid}, 16'd0);

    // Warm-up: 5,1,4,2,3 then 9,9,0 streamed back-to-back
    cycle(1'b1, 16'd5, 1'b1, 1'b0);
    chk("warm1_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd1, 1'b1, 1'b0);
    chk("warm2_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd4, 1'b1, 1'b0);
    chk("warm3_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd2, 1'b1, 1'b0);
    chk("warm4_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd3, 1'b1, 1'b0);
    chk("fifth_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd9, 1'b1, 1'b0);
    chk("lat1_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd9, 1'b1, 1'b0);
    chk("first_valid", {15'b0, bus.out_valid}, 16'd1);
    chk("first_data", bus.out_data, 16'd3);
    cycle(1'b1, 16'd0, 1'b1, 1'b0);
    chk("w2_data", bus.out_data, 16'd3);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("w3_valid", {15'b0, bus.out_valid}, 16'd1);
    chk("w3_data", bus.out_data, 16'd4);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("w4_data", bus.out_data, 16'd3);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("bubble_valid", {15'b0, bus.out_valid}, 16'd0);

    // Stall: windows {5,0,9,9,3}=5 {6,5,0,9,9}=6 {1,6,5,0,9}=5 {2,1,6,5,0}=2
    cycle(1'b1, 16'd5, 1'b1, 1'b0);
    cycle(1'b1, 16'd6, 1'b1, 1'b0);
    cycle(1'b1, 16'd1, 1'b1, 1'b0);
    chk("pre_stall_data", bus.out_data, 16'd5);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'd2, 1'b0, 1'b0);
      chk("stall_in_ready", {15'b0, bus.in_ready}, 16'd0);
      chk("stall_valid", {15'b0, bus.out_valid}, 16'd1);
      chk("stall_data", bus.out_data, 16'd5);
    end
    cycle(1'b1, 16'd2, 1'b1, 1'b0);
    chk("resume1_data", bus.out_data, 16'd6);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("resume2_data", bus.out_data, 16'd5);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("resume3_valid", {15'b0, bus.out_valid}, 16'd1);
    chk("resume3_data", bus.out_data, 16'd2);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("drain_valid", {15'b0, bus.out_valid}, 16'd0);

    // Clear while a job is in flight, then refill with 10..50
    cycle(1'b1, 16'd7, 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b1, 1'b1);
    chk("clear_in_ready", {15'b0, bus.in_ready}, 16'd0);
    chk("clear_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd10, 1'b1, 1'b0);
    chk("flushed_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd20, 1'b1, 1'b0);
    chk("clr2_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd30, 1'b1, 1'b0);
    chk("clr3_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd40, 1'b1, 1'b0);
    chk("clr4_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd50, 1'b1, 1'b0);
    chk("clr5_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd60, 1'b1, 1'b0);
    chk("clr6_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd70, 1'b1, 1'b0);
    chk("clr_out_valid", {15'b0, bus.out_valid}, 16'd1);
    chk("clr_out_data", bus.out_data, 16'd30);

    // Asynchronous reset pulse between clock edges
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {15'b0, bus.out_valid}, 16'd0);
    chk("arst_data", bus.out_data, 16'd0);
    chk("arst_in_ready", {15'b0, bus.in_ready}, 16'd0);
    #1 reset = 1'b1;
    cycle(1'b1, 16'd100, 1'b1, 1'b0);
    chk("post_rst1_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd50, 1'b1, 1'b0);
    chk("post_rst2_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd75, 1'b1, 1'b0);
    chk("post_rst3_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd25, 1'b1, 1'b0);
    chk("post_rst4_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b1, 16'd60, 1'b1, 1'b0);
    chk("post_rst5_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("post_rst6_valid", {15'b0, bus.out_valid}, 16'd0);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("post_rst_valid", {15'b0, bus.out_valid}, 16'd1);
    chk("post_rst_data", bus.out_data, 16'd60);

    // Signedness: -1,1,2,-32768,3 -> signed median 1, unsigned median 3
`ifdef MEDIAN5_SIGNED_EN
    signed_exp = 16'd1;
`else
    signed_exp = 16'd3;
`endif
    cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
    cycle(1'b1, 16'h0001, 1'b1, 1'b0);
    cycle(1'b1, 16'h0002, 1'b1, 1'b0);
    cycle(1'b1, 16'h8000, 1'b1, 1'b0);
    cycle(1'b1, 16'h0003, 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("sign_valid", {15'b0, bus.out_valid}, 16'd1);
    chk("sign_data", bus.out_data, signed_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
